// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter unit
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int          ILEN_BYTES32         = 4;
    localparam int          ILEN_BYTES16         = 2;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_target_check.sv
// rtl/pc_target_check.sv - redirect target alignment checker (PC_UNIT_RVC_EN relaxes to 2-byte)
module pc_target_check #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] target,
    output logic            misaligned
);

`ifdef PC_UNIT_RVC_EN
    // Compressed instructions allowed: only halfword alignment is required
    logic unused_bits;
    assign unused_bits = ^target[XLEN-1:1];
    assign misaligned  = target[0];
`else
    // Only 32-bit instructions: targets must be word aligned
    logic unused_bits;
    assign unused_bits = ^target[XLEN-1:2];
    assign misaligned  = |target[1:0];
`endif

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - next-PC stage with trap/redirect priority, stall hold and misalignment halt (PC_UNIT_RVC_EN)
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            instr_len2,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] PC_plus,
    output logic            fetch_valid,
    output logic [XLEN-1:0] epc_out,
    output logic            misaligned,
    output logic [XLEN-1:0] misaligned_addr
);

    pc_state_t       state;
    logic            target_bad;
    logic [XLEN-1:0] trap_target;

    pc_target_check #(
        .XLEN(XLEN)
    ) u_target_check (
        .target    (redirect_target),
        .misaligned(target_bad)
    );

`ifdef PC_UNIT_RVC_EN
    // Link/sequential value follows the length of the current instruction
    assign PC_plus     = PC_out + (instr_len2 ? XLEN'(ILEN_BYTES16) : XLEN'(ILEN_BYTES32));
    assign trap_target = trap_vector & ~XLEN'(1);
`else
    // Fixed 4-byte step; the length hint has no meaning without compressed support
    logic unused_len2;
    assign unused_len2 = instr_len2;
    assign PC_plus     = PC_out + XLEN'(ILEN_BYTES32);
    assign trap_target = trap_vector & ~XLEN'(3);
`endif

    // Control FSM: PC selection, trap capture, misalignment pulse and halt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= BOOT;
            PC_out          <= RESET_VECTOR;
            fetch_valid     <= 1'b0;
            epc_out         <= '0;
            misaligned      <= 1'b0;
            misaligned_addr <= '0;
        end else begin
            misaligned <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (trap_valid) begin
                        PC_out  <= trap_target;
                        epc_out <= PC_out;
                    end else if (redirect_valid) begin
                        if (target_bad) begin
                            state           <= HALT;
                            fetch_valid     <= 1'b0;
                            misaligned      <= 1'b1;
                            misaligned_addr <= redirect_target;
                        end else begin
                            PC_out <= redirect_target;
                        end
                    end else if (!stall && fetch_ready) begin
                        PC_out <= PC_plus;
                    end
                end
                HALT: begin
                    if (trap_valid) begin
                        PC_out      <= trap_target;
                        epc_out     <= PC_out;
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed scoreboard bench for pc_unit (covers PC_UNIT_RVC_EN when defined)
module tb_pc_unit;

    localparam int XLEN = 32;

    localparam int S_PC   = 0;
    localparam int S_PLUS = 1;
    localparam int S_FV   = 2;
    localparam int S_EPC  = 3;
    localparam int S_MIS  = 4;
    localparam int S_MADR = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            fetch_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic            instr_len2;
    logic [XLEN-1:0] PC_out;
    logic [XLEN-1:0] PC_plus;
    logic            fetch_valid;
    logic [XLEN-1:0] epc_out;
    logic            misaligned;
    logic [XLEN-1:0] misaligned_addr;

    chk_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    pc_unit #(
        .XLEN(XLEN),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .instr_len2     (instr_len2),
        .PC_out         (PC_out),
        .PC_plus        (PC_plus),
        .fetch_valid    (fetch_valid),
        .epc_out        (epc_out),
        .misaligned     (misaligned),
        .misaligned_addr(misaligned_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_PC:    return PC_out;
            S_PLUS:  return PC_plus;
            S_FV:    return {31'd0, fetch_valid};
            S_EPC:   return epc_out;
            S_MIS:   return {31'd0, misaligned};
            S_MADR:  return misaligned_addr;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        chk_t c;
        c.tag = tag;
        c.sel = sel;
        c.exp = exp;
        sb.push_back(c);
    endtask

    task automatic expect_core(input string tag, input logic [31:0] pc,
                               input logic fv, input logic mis);
        expect_val({tag, ".pc"}, S_PC, pc);
        expect_val({tag, ".fv"}, S_FV, {31'd0, fv});
        expect_val({tag, ".mis"}, S_MIS, {31'd0, mis});
    endtask

    task automatic drain();
        chk_t        c;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            c   = sb.pop_front();
            obs = observe(c.sel);
            vectors++;
            assert (obs === c.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", c.tag, obs, c.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        stall           = 1'b0;
        fetch_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        trap_valid      = 1'b0;
        trap_vector     = '0;
        instr_len2      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_core("rst", 32'h0, 1'b0, 1'b0);
        expect_val("rst.plus", S_PLUS, 32'h4);
        expect_val("rst.epc", S_EPC, 32'h0);
        expect_val("rst.madr", S_MADR, 32'h0);
        drain();
        reset = 1'b0;
        expect_core("boot", 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        do_reset();

        expect_core("seq4", 32'h4, 1'b1, 1'b0);  tick();
        expect_core("seq8", 32'h8, 1'b1, 1'b0);  tick();
`ifdef PC_UNIT_RVC_EN
        instr_len2 = 1'b1;
        expect_core("rvc_len2", 32'hA, 1'b1, 1'b0);  tick();
        instr_len2 = 1'b0;
        expect_core("rvc_seq", 32'hE, 1'b1, 1'b0);   tick();
`else
        instr_len2 = 1'b1;
        expect_core("seq12_len2_ignored", 32'hC, 1'b1, 1'b0);  tick();
        instr_len2 = 1'b0;
`endif

        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        expect_core("redir", 32'h100, 1'b1, 1'b0);
        expect_val("redir.plus", S_PLUS, 32'h104);
        tick();
        redirect_valid = 1'b0;

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_core("stall", 32'h100, 1'b1, 1'b0);
            tick();
        end
        stall       = 1'b0;
        fetch_ready = 1'b0;
        expect_core("backpressure", 32'h100, 1'b1, 1'b0);  tick();
        fetch_ready = 1'b1;
        expect_core("resume", 32'h104, 1'b1, 1'b0);        tick();

`ifdef PC_UNIT_RVC_EN
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        expect_core("rvc_half_ok", 32'h102, 1'b1, 1'b0);   tick();
        redirect_target = 32'h103;
        expect_core("misal", 32'h102, 1'b0, 1'b1);
        expect_val("misal.madr", S_MADR, 32'h103);
        tick();
        redirect_target = 32'h300;
        expect_core("halt_ign", 32'h102, 1'b0, 1'b0);
        expect_val("halt_ign.madr", S_MADR, 32'h103);
        tick();
        redirect_valid = 1'b0;
        trap_valid     = 1'b1;
        trap_vector    = 32'h201;
        expect_core("halt_trap", 32'h200, 1'b1, 1'b0);
        expect_val("halt_trap.epc", S_EPC, 32'h102);
        tick();
`else
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        expect_core("misal", 32'h104, 1'b0, 1'b1);
        expect_val("misal.madr", S_MADR, 32'h102);
        tick();
        redirect_target = 32'h300;
        expect_core("halt_ign", 32'h104, 1'b0, 1'b0);
        expect_val("halt_ign.madr", S_MADR, 32'h102);
        tick();
        redirect_valid = 1'b0;
        trap_valid     = 1'b1;
        trap_vector    = 32'h203;
        expect_core("halt_trap", 32'h200, 1'b1, 1'b0);
        expect_val("halt_trap.epc", S_EPC, 32'h104);
        tick();
`endif

        trap_vector     = 32'h80;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        stall           = 1'b1;
        expect_core("trap_wins", 32'h80, 1'b1, 1'b0);
        expect_val("trap_wins.epc", S_EPC, 32'h200);
        tick();
        trap_valid      = 1'b0;
        stall           = 1'b0;
        redirect_target = 32'hFFFF_FFFC;
        expect_core("pre_wrap", 32'hFFFF_FFFC, 1'b1, 1'b0);
        expect_val("pre_wrap.plus", S_PLUS, 32'h0);
        tick();
        redirect_valid = 1'b0;
        expect_core("wrap", 32'h0, 1'b1, 1'b0);            tick();
        expect_core("post_wrap", 32'h4, 1'b1, 1'b0);       tick();

        reset = 1'b1;
        #2;
        expect_core("async_rst", 32'h0, 1'b0, 1'b0);
        expect_val("async_rst.epc", S_EPC, 32'h0);
        expect_val("async_rst.madr", S_MADR, 32'h0);
        drain();
        do_reset();
        expect_core("after_rst", 32'h4, 1'b1, 1'b0);       tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle RISC-V core. It replaces the plain registered PC with a self-contained next-PC stage, and sits between the instruction-memory fetch port and the branch/jump/trap logic. It generates sequential PCs itself, and accepts redirects and trap vectors with fixed priority. It holds on stall or a fetch backpressure cycle, and detects misaligned redirect targets before they reach instruction memory.

## Interface
- XLEN, 32, PC and target width
- RESET_VECTOR, 32'h0000_0000, PC_out value during and after reset
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- stall  input  1  hold PC (hazard/multi-cycle op)
- fetch_ready  input  1  instruction memory accepts PC_out this cycle
- redirect_valid  input  1  branch taken / jump
- redirect_target  input  XLEN  redirect destination
- trap_valid  input  1  exception/interrupt entry
- trap_vector  input  XLEN  trap handler address (mtvec)
- instr_len2  input  1  current instruction is 16-bit (ignored unless PC_UNIT_RVC_EN)
- PC_out  output  XLEN  current fetch PC
- PC_plus  output  XLEN  PC_out + instruction length (link value for JAL/JALR)
- fetch_valid  output  1  PC_out is a valid fetch request
- epc_out  output  XLEN  PC_out captured at last trap entry
- misaligned  output  1  one-cycle pulse, misaligned redirect rejected
- misaligned_addr  output  XLEN  offending target, held until next misalignment

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on reset; fetch_valid=0; after one clock with reset low → RUN.
- RUN, per cycle, priority order:
  - trap_valid: PC ← trap_vector, epc_out ← PC_out.
  - redirect_valid, target aligned: PC ← redirect_target.
  - redirect_valid, target misaligned: PC held; misaligned=1 for one cycle; misaligned_addr ← target; → HALT.
  - stall or !fetch_ready: PC held.
  - otherwise: PC ← PC_plus.
- HALT: fetch_valid=0, PC held; only trap_valid leaves it (PC ← trap_vector, epc_out ← PC_out, → RUN). redirect_valid is ignored in HALT.
- Alignment rule: target[1:0] must be 2'b00.
- PC_plus = PC_out + 4. Sum is modulo 2^XLEN, so 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Trap beats redirect, stall and backpressure in the same cycle. trap_vector is not alignment-checked; bits [1:0] are forced to 0.

## Timing
- Reset values:
  - PC_out = RESET_VECTOR
  - PC_plus = RESET_VECTOR+4
  - fetch_valid = 0
  - epc_out = 0
  - misaligned = 0
  - misaligned_addr = 0
  - state = BOOT
- Reset mid-operation clears all state immediately, asynchronously.
- All state updates on the rising edge of clk. Redirect or trap seen at edge N → PC_out holds the new value after edge N, i.e. one cycle latency.
- PC_plus is combinational from PC_out (and instr_len2); there is no extra register.
- misaligned asserts in the cycle after the offending edge and lasts exactly one cycle.
- fetch_valid = (state == RUN).

## Configuration
- PC_UNIT_RVC_EN defined:
  - PC_plus = PC_out + (instr_len2 ? 2 : 4).
  - Alignment rule relaxes to target[0] == 0.
  - trap_vector bit 0 is forced to 0.
- Undefined: instr_len2 is ignored, increment is always 4, 4-byte alignment applies.

## Structure
- Shared package pc_pkg holds:
  - state typedef (BOOT/RUN/HALT)
  - ILEN_BYTES32 = 4 and ILEN_BYTES16 = 2 constants
  - default RESET_VECTOR constant
- One sub-module, pc_target_check: combinational alignment checker (target in, misaligned flag out), sensitive to PC_UNIT_RVC_EN.

## Test plan
- Reset sequencing: reset high 2 cycles, release, fetch_ready=1 → PC_out 0, 0 (BOOT), 4, 8, 12; fetch_valid rises after the BOOT cycle.
- Redirect, then backpressure:
  - redirect_valid=1, target 32'h100 → next PC_out 32'h100, PC_plus 32'h104.
  - stall=1 for 3 cycles → PC_out stays 32'h100.
- Misaligned redirect: redirect to 32'h102 → misaligned pulses 1 cycle, misaligned_addr 32'h102, fetch_valid 0. Then trap_valid with vector 32'h200 → PC_out 32'h200, epc_out = held PC, back to RUN.
- Trap beats redirect:
  - trap_valid (vector 32'h80) and redirect_valid (target 32'h40) in the same cycle → PC_out 32'h80.
  - Wrap-around: PC 32'hFFFF_FFFC advances to 0.
- RVC (PC_UNIT_RVC_EN defined):
  - instr_len2=1 at PC 8 → next PC 10.
  - redirect to 32'h102 is accepted.
  - redirect to 32'h103 raises misaligned.
